// File: rtl/control_suma_multipalabra.sv
// -----------------------------------------------------------------------------
// control_suma_multipalabra
//
// Multi-precision add/subtract sequencer. A WORDS*N-bit sum or difference is
// computed one N-bit word per cycle through a single sumadorNbits instance.
// A registered carry chains the words from the least significant word to the
// most significant word. This keeps the critical path to one N-bit ripple
// instead of a full-width adder.
//
// Parameters:
//   N      word width handled per cycle (default 8)
//   WORDS  number of words, operand width W = N*WORDS (default 4, >= 1)
//
// Ports:
//   clk    rising-edge clock
//   rst    synchronous active-high reset
//   start  operation request, sampled only while idle
//   op     0 = A+B, 1 = A-B, latched with start
//   A, B   W-bit operands, latched with start
//   busy   high while words are being processed
//   done   one-cycle pulse, Q/Cout/V are valid
//   Q      W-bit result register
//   Cout   carry out of the top word (for subtract, 1 = no borrow)
//   V      two's-complement overflow of the full W-bit result
// -----------------------------------------------------------------------------

// One N-bit ripple adder slice with carry in and carry out.
module sumadorNbits #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] s,
    output logic         cout
);

    always_comb begin
        {cout, s} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
    end

endmodule

module control_suma_multipalabra #(
    parameter int N     = 8,
    parameter int WORDS = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               op,
    input  logic [N*WORDS-1:0] A,
    input  logic [N*WORDS-1:0] B,
    output logic               busy,
    output logic               done,
    output logic [N*WORDS-1:0] Q,
    output logic               Cout,
    output logic               V
);

    localparam int W    = N * WORDS;
    localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;

    logic [W-1:0]    a_r;
    logic [W-1:0]    b_r;
    logic [IDXW-1:0] idx;
    logic            carry;

    logic [N-1:0]    a_word;
    logic [N-1:0]    b_word;
    logic [N-1:0]    sum_word;
    logic            sum_cout;
    logic            last_word;

    // Word selection: only an N-bit mux sits in front of the adder, so there
    // is never a W-bit combinational path. b_r already holds ~B for subtract
    // and the initial carry supplies the +1.
    always_comb begin
        a_word = '0;
        b_word = '0;
        for (int w = 0; w < WORDS; w++) begin
            if (idx == IDXW'(w)) begin
                a_word = a_r[w*N +: N];
                b_word = b_r[w*N +: N];
            end
        end
    end

    assign last_word = (idx == IDX_LAST);

    sumadorNbits #(.N(N)) u_sumador (
        .a   (a_word),
        .b   (b_word),
        .cin (carry),
        .s   (sum_word),
        .cout(sum_cout)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. DONE always returns to IDLE so a held start is
    // accepted again only one cycle later.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_word) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Status outputs decoded purely from the state.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (state)
            RUN:     busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Datapath: operand latch, word counter, carry chain and result registers.
    // Cout and V are only updated on the final word so they hold the previous
    // result until the new one is complete; idx is cleared there instead of
    // wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r   <= '0;
            b_r   <= '0;
            idx   <= '0;
            carry <= 1'b0;
            Q     <= '0;
            Cout  <= 1'b0;
            V     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a_r   <= A;
                        b_r   <= op ? ~B : B;
                        carry <= op;
                        idx   <= '0;
                    end
                end
                RUN: begin
                    for (int w = 0; w < WORDS; w++) begin
                        if (idx == IDXW'(w)) begin
                            Q[w*N +: N] <= sum_word;
                        end
                    end
                    carry <= sum_cout;
                    if (last_word) begin
                        Cout <= sum_cout;
                        V    <= (a_word[N-1] == b_word[N-1]) &&
                                (sum_word[N-1] != a_word[N-1]);
                        idx  <= '0;
                    end else begin
                        idx  <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/control_suma_multipalabra.md
# control_suma_multipalabra

Multi-precision add/subtract sequencer for the ALU. It computes WORDS×N-bit sums and differences by time-multiplexing one internal `sumadorNbits #(N)` instance. The instance handles one N-bit word per cycle, and a registered carry chains the words from LSW to MSW. It sits beside the combinational ALU path and serves wide operations where a full-width ripple adder would break timing.

## Interface
Parameters:
- `N`, default 8: word width fed to the internal `sumadorNbits`.
- `WORDS`, default 4: number of words; operand width is W = N*WORDS, and WORDS ≥ 1.

Ports:
- `clk` in, 1: single clock, rising edge.
- `rst` in, 1: reset, synchronous, active-high.
- `start` in, 1: request an operation. Sampled only in IDLE.
- `op` in, 1: 0 = A+B, 1 = A−B. Latched with `start`.
- `A` in, W: first operand. Latched with `start`.
- `B` in, W: second operand. Latched with `start`.
- `busy` out, 1: high while in RUN.
- `done` out, 1: one-cycle pulse; result is valid.
- `Q` out, W: result register.
- `Cout` out, 1: carry out of MSW. For subtract, 1 = no borrow.
- `V` out, 1: two's-complement overflow of the full W-bit result.

## Operation
- One clock domain. Reset is synchronous and active-high.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - `busy` = 0 and `done` = 0.
  - On an edge with `start` = 1: latch A into `a_r` and B into `b_r`, with `b_r` = ~B when `op` = 1.
  - On the same edge: `carry` ← `op`, `idx` ← 0, and go to RUN.
- RUN:
  - `busy` = 1.
  - The adder inputs are word `idx` of `a_r`, word `idx` of `b_r`, and Cin = `carry`.
  - Each edge:
    - Write the sum into `Q[idx*N +: N]`.
    - `carry` ← adder Cout.
    - `idx` ← `idx`+1.
  - On the edge where `idx` = WORDS−1: also load `Cout` ← adder Cout and `V` ← (a_msb == b_msb) && (sum_msb != a_msb), using the MSW bits. Then go to DONE.
- DONE:
  - `done` = 1 and `busy` = 0 for exactly one cycle, then IDLE.
- `start` in RUN or DONE is ignored; it is not queued.
- `start` held high is accepted again on the first IDLE edge after DONE.
- `Q`, `Cout` and `V` hold their values from DONE until the next accepted `start`.
  - `Q` words are overwritten progressively during the next RUN.
  - `Cout` and `V` hold until that RUN's last edge.
- Changes on the A, B and `op` inputs after the accept edge have no effect.
- Arithmetic is modulo 2^W. `Cout` is bit W of A + (op ? ~B : B) + op.
- `idx` has width clog2(WORDS), minimum 1 bit. It never wraps past WORDS−1 inside RUN.
- With WORDS = 1, RUN lasts exactly one cycle.

## Timing
- Reset values: state IDLE, `busy` 0, `done` 0, `Q` 0, `Cout` 0, `V` 0, `idx` 0, `carry` 0.
- Reset asserted in any state aborts the operation on that edge: no `done`, and all outputs return to reset values.
- Latency, with `start` sampled at edge e0:
  - `busy` is high after edges e0 … e(WORDS−1).
  - `done` is high after edge e(WORDS) for one cycle.
  - Total latency is WORDS+1 cycles.
- Throughput: one operation per WORDS+2 cycles when `start` is held.
- Critical path: one N-bit ripple plus the carry register. There is no W-bit combinational path.

## Test plan
All scenarios use N = 8, WORDS = 4.
- **Add with full carry ripple:** A = 0xFFFFFFFF, B = 0x00000001, op = 0 → `Q` = 0x00000000, `Cout` = 1, `V` = 0. `done` is high exactly 5 cycles after the `start` edge; `busy` is high for 4 cycles.
- **Subtract with borrow:** A = 5, B = 7, op = 1 → `Q` = 0xFFFFFFFE, `Cout` = 0, `V` = 0.
- **Signed overflow:**
  - A = 0x7FFFFFFF, B = 1, add → `Q` = 0x80000000, `V` = 1, `Cout` = 0.
  - A = 0x80000000, B = 1, sub → `Q` = 0x7FFFFFFF, `V` = 1, `Cout` = 1.
- **Start ignored while busy:** start A = 0x12345678 + B = 0x11111111. Pulse `start` with different operands on cycles 2 and 5 (DONE cycle). Result is `Q` = 0x23456789, only one `done` pulse occurs, and the module returns to IDLE.
- **Reset mid-operation:** assert `rst` on cycle 2 of RUN → the next cycle shows all outputs 0, state IDLE, and no `done`. A new add of 1 + 1 then gives `Q` = 2 with normal latency.
- **Back-to-back and random:** hold `start` high → `done` every 6 cycles. Compare 1000 random A/B/op against a W-bit reference model for `Q`, `Cout` and `V`.
